// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters and the shared-mux arbiter.
// The arbiter takes the slave side, the requesters the master side.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output busy,
    output timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 single-bit mux with a one-cycle
// break-before-make gap and optional hold-limit preemption.
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic               sysclk,
  input logic               sys_rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  localparam int CW = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HMAX = CW'(HOLD_MAX);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    win;
  logic [1:0]    idx;
  logic          hit;
  logic          own;
  logic          others;
  logic          preempt;

  // First set request walking upward from the priority pointer.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!hit && bus.req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  assign own     = bus.req[sel_q];
  assign others  = |(bus.req & ~(4'b0001 << sel_q));
  assign preempt = (HOLD_MAX != 0) && (cnt_q == HMAX) && others;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          busy_d  = 1'b1;
          cnt_d   = ONE;
          state_d = GRANT;
        end else begin
          gnt_d  = 4'b0000;
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (!own || preempt) begin
          // A plain release wins over a simultaneous preempt.
          timeout_d = own;
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          cnt_d     = '0;
          ptr_d     = sel_q + 2'd1;
          state_d   = GAP;
        end else if (HOLD_MAX != 0 && cnt_q != HMAX) begin
          cnt_d = cnt_q + ONE;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 single-bit multiplexer between four requesters.
- Drives the multiplexer's 2-bit select and returns a one-hot grant to the winning requester.
- Break-before-make: one dead cycle between owners.
- Optional hold limit preempts a requester that keeps ownership too long while others wait.

Parameters:
- HOLD_MAX, 8: maximum consecutive grant cycles before forced release if another request is pending; 0 disables preemption.

Ports:
- sysclk  input  1  system clock, all state updates on rising edge
- sys_rst_n  input  1  asynchronous active-low reset
- req  input  4  request per requester, level-sensitive, bit i = requester i
- gnt  output  4  one-hot grant, registered; all-zero when no owner
- sel  output  2  multiplexer select, registered; equals index of current/last owner
- busy  output  1  high while an owner holds the multiplexer
- timeout  output  1  one-cycle pulse when an owner is preempted by HOLD_MAX

Behaviour:
- Reset values (asynchronous, immediate on sys_rst_n low):
  - Outputs: gnt=4'b0000, sel=2'b00, busy=0, timeout=0.
  - Internal: priority pointer ptr=0, hold counter=0, state=IDLE.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req!=0 at a rising edge, grant the first set bit searching ptr, ptr+1, ... mod 4.
  - At that edge: gnt=one-hot(winner), sel=winner, busy=1, counter=1, go to GRANT.
  - Latency: req sampled high at edge N gives gnt high after edge N.
  - If req==0: stay in IDLE with gnt=0.
- GRANT, release: if req[owner]==0 at an edge:
  - gnt=0, busy=0, ptr=owner+1 mod 4, go to GAP.
  - Requests from other bits do not matter.
- GRANT, preempt: if HOLD_MAX!=0, counter==HOLD_MAX, req[owner]==1 and any other req bit set:
  - gnt=0, busy=0, timeout=1 for that one cycle, ptr=owner+1 mod 4, go to GAP.
- GRANT, hold:
  - Otherwise stay in GRANT.
  - Counter increments, saturating at HOLD_MAX.
  - With no competitor, the grant continues indefinitely.
- GAP:
  - Exactly one cycle with gnt=0, then go to IDLE.
  - req is ignored during GAP.
  - IDLE arbitrates at the next edge, so the minimum owner-to-owner turnaround is 2 dead cycles after the release edge.
- sel:
  - Changes only on the edge that issues a new grant.
  - Holds (parks) the last owner's index through GAP and IDLE.
  - Never changes while gnt!=0.
- gnt is always one-hot or zero, never multi-hot.
- Counter width: clog2(HOLD_MAX+1), minimum 1 bit.
- ptr rotates only on release or preempt, never on a grant.
- Simultaneous release and preempt condition: treat as release, timeout=0.
- Owner deasserts and reasserts req: treated as release, then a fresh request under the rotated ptr.
- Reset mid-grant:
  - Outputs clear asynchronously; no GAP cycle is produced.
  - After reset release, arbitration restarts from ptr=0.
- Synthesizable: no latches, no X assignment on outputs.

Test Plan:
- Reset, then req=4'b0101 held:
  - After the next edge: gnt=0001, sel=00, busy=1.
  - Drop req[0]: gnt=0000 for 2 cycles, then gnt=0100, sel=10.
- Fairness: req=4'b1111 held continuously with HOLD_MAX=8:
  - Grants rotate 0,1,2,3,0.
  - Each grant lasts 8 cycles, then timeout=1 for exactly one cycle; sel follows 00,01,10,11,00.
- Single requester: req=4'b1000 held 50 cycles with HOLD_MAX=8.
  - gnt=1000 throughout; timeout never pulses; sel=11.
- HOLD_MAX=0: req=4'b0011 held 40 cycles.
  - Requester 0 keeps gnt=0001 the whole time; timeout=0.
  - Release req[0]: gnt=0010 two cycles later.
- Reset mid-grant: assert sys_rst_n=0 between clock edges while gnt=0100.
  - gnt=0000, sel=00, busy=0 immediately, without waiting for an edge.
  - After release with req=4'b0110: gnt=0010.
- Glitch and GAP: owner req[2] drops for 1 cycle and returns, with req[3]=1 during GAP.
  - GAP ignores both; IDLE then grants 3 (ptr=3); requester 2 waits.
  - sel holds 10 until the grant to 3, then becomes 11.
